// File: rtl/cpu_decode_pkg.sv
// Shared decode types and opcode constants for the fetch -> decode -> execute path.
package CPU_Defines;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  // Encodings match funct3 so execute can compare directly against the instruction.
  typedef enum logic [2:0] {
    BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100,
    BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111
  } branch_cond_t;

  typedef enum logic [3:0] {
    SYS_NONE, SYS_ECALL, SYS_EBREAK, SYS_MRET, SYS_WFI,
    SYS_CSRRW, SYS_CSRRS, SYS_CSRRC, SYS_CSRRWI, SYS_CSRRSI, SYS_CSRRCI
  } sys_op_t;

  typedef struct packed {
    logic        strobe;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [4:0]  inst_rs1;
    logic [4:0]  inst_rs2;
    logic [4:0]  inst_rd;
  } fetch_data_t;

  typedef struct packed {
    logic         strobe;
    logic [31:0]  pc;
    logic [31:0]  instruction;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [31:0]  imm;
    alu_op_t      alu_op;
    branch_cond_t branch_cond;
    logic [1:0]   mem_width;
    logic         mem_signed;
    logic         is_load;
    logic         is_store;
    logic         is_branch;
    logic         is_jal;
    logic         is_jalr;
    logic         is_lui;
    logic         is_auipc;
    logic         is_op_imm;
    logic         is_op;
    logic         is_system;
    sys_op_t      sys_op;
    logic         is_muldiv;
    logic [2:0]   muldiv_op;
    logic         illegal;
  } decode_data_t;

endpackage

// File: rtl/cpu_decode_if.sv
// Fetch-side and execute-side packet bus of the decode stage.
interface cpu_decode_if;
  import CPU_Defines::*;

  fetch_data_t  i_data;
  logic         i_busy;
  logic         o_busy;
  decode_data_t o_data;

  modport master (output i_data, output i_busy, input o_busy, input o_data);
  modport slave  (input i_data, input i_busy, output o_busy, output o_data);
endinterface

// File: rtl/cpu_decode_logic.sv
// Combinational RV32I decode of one instruction; the strobe field is left at 0.
// Optional M-extension decode enabled by CPU_DECODE_RV32M_EN.
module cpu_decode_logic
  import CPU_Defines::*;
(
  input  logic [31:0]  instruction,
  input  logic [31:0]  pc,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  input  logic [4:0]   rd,
  output decode_data_t dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  function automatic alu_op_t base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = signed'({{20{instruction[31]}}, instruction[31:20]});
  assign imm_s = signed'({{20{instruction[31]}}, instruction[31:25], instruction[11:7]});
  assign imm_b = signed'({{19{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0});
  assign imm_u = signed'({instruction[31:12], 12'h000});
  assign imm_j = signed'({{11{instruction[31]}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0});

  always_comb begin
    dec             = '0;
    dec.pc          = pc;
    dec.instruction = instruction;
    dec.rs1         = rs1;
    dec.rs2         = rs2;
    dec.rd          = rd;
    dec.alu_op      = ALU_ADD;
    dec.branch_cond = BR_EQ;
    dec.sys_op      = SYS_NONE;
    dec.mem_width   = funct3[1:0];
    dec.mem_signed  = ~funct3[2];
    case (opcode)
      OPC_LOAD: begin
        dec.is_load = 1'b1;
        dec.imm     = imm_i;
        dec.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.is_store = 1'b1;
        dec.imm      = imm_s;
        dec.illegal  = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        dec.is_op_imm = 1'b1;
        dec.imm       = imm_i;
        dec.alu_op    = base_alu(funct3);
        if (funct3 == 3'b001)
          dec.illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000)      dec.alu_op  = ALU_SRA;
          else if (funct7 != 7'b0000000) dec.illegal = 1'b1;
        end
      end
      OPC_OP: begin
        dec.is_op = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_op = base_alu(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.alu_op  = ALU_SUB;
            else if (funct3 == 3'b101) dec.alu_op  = ALU_SRA;
            else                       dec.illegal = 1'b1;
          end
`ifdef CPU_DECODE_RV32M_EN
          7'b0000001: begin
            dec.is_muldiv = 1'b1;
            dec.muldiv_op = funct3;
          end
`else
          7'b0000001: dec.illegal = 1'b1;
`endif
          default:    dec.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec.is_branch   = 1'b1;
        dec.imm         = imm_b;
        dec.illegal     = (funct3[2:1] == 2'b01);
        if (funct3[2:1] != 2'b01) dec.branch_cond = branch_cond_t'(funct3);
      end
      OPC_JAL:   begin dec.is_jal = 1'b1; dec.imm = imm_j; end
      OPC_JALR:  begin dec.is_jalr = 1'b1; dec.imm = imm_i; dec.illegal = (funct3 != 3'b000); end
      OPC_LUI:   begin dec.is_lui = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_PASS_B; end
      OPC_AUIPC: begin dec.is_auipc = 1'b1; dec.imm = imm_u; end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        dec.is_system = 1'b1;
        dec.imm       = imm_i;
        case (funct3)
          3'b000: begin
            case (instruction)
              32'h00000073: dec.sys_op = SYS_ECALL;
              32'h00100073: dec.sys_op = SYS_EBREAK;
              32'h30200073: dec.sys_op = SYS_MRET;
              32'h10500073: dec.sys_op = SYS_WFI;
              default:      dec.illegal = 1'b1;
            endcase
          end
          3'b001:  dec.sys_op = SYS_CSRRW;
          3'b010:  dec.sys_op = SYS_CSRRS;
          3'b011:  dec.sys_op = SYS_CSRRC;
          3'b101:  dec.sys_op = SYS_CSRRWI;
          3'b110:  dec.sys_op = SYS_CSRRSI;
          3'b111:  dec.sys_op = SYS_CSRRCI;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    if (instruction[1:0] != 2'b11) dec.illegal = 1'b1;
  end

endmodule

// File: rtl/cpu_decode.sv
// Decode stage: toggle-strobe input, one-entry skid for backpressure, registered output.
// Optional RV32M decode via CPU_DECODE_RV32M_EN (see cpu_decode_logic).
module cpu_decode
  import CPU_Defines::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  cpu_decode_if.slave bus
);

  logic         last_strobe;
  logic         skid_valid;
  logic [31:0]  skid_pc_p0;
  logic [31:0]  skid_instr_p0;
  logic [4:0]   skid_rs1_p0;
  logic [4:0]   skid_rs2_p0;
  logic [4:0]   skid_rd_p0;
  decode_data_t out_p1;
  decode_data_t dec;
  logic         new_input;

  assign new_input  = (bus.i_data.strobe != last_strobe);
  assign bus.o_busy = bus.i_busy | skid_valid;
  assign bus.o_data = out_p1;

  // The skid, when occupied, always feeds the decoder ahead of the live input.
  cpu_decode_logic u_logic (
    .instruction (skid_valid ? skid_instr_p0 : bus.i_data.instruction),
    .pc          (skid_valid ? skid_pc_p0    : bus.i_data.pc),
    .rs1         (skid_valid ? skid_rs1_p0   : bus.i_data.inst_rs1),
    .rs2         (skid_valid ? skid_rs2_p0   : bus.i_data.inst_rs2),
    .rd          (skid_valid ? skid_rd_p0    : bus.i_data.inst_rd),
    .dec         (dec)
  );

  // p0 -> p1: skid capture and output register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      out_p1      <= '0;
      skid_valid  <= 1'b0;
      last_strobe <= 1'b0;
    end else begin
      if (new_input) last_strobe <= bus.i_data.strobe;
      if (skid_valid) begin
        if (!bus.i_busy) begin
          out_p1        <= dec;
          out_p1.strobe <= ~out_p1.strobe;
          skid_valid    <= 1'b0;
        end
        if (new_input) $display("decode overflow");
      end else if (new_input) begin
        if (!bus.i_busy) begin
          out_p1        <= dec;
          out_p1.strobe <= ~out_p1.strobe;
        end else begin
          skid_valid <= 1'b1;
        end
      end
    end
  end

  // Skid payload carries no reset; skid_valid alone qualifies it.
  always_ff @(posedge i_clock) begin
    if (!skid_valid && new_input && bus.i_busy) begin
      skid_pc_p0    <= bus.i_data.pc;
      skid_instr_p0 <= bus.i_data.instruction;
      skid_rs1_p0   <= bus.i_data.inst_rs1;
      skid_rs2_p0   <= bus.i_data.inst_rs2;
      skid_rd_p0    <= bus.i_data.inst_rd;
    end
  end

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: decode vectors, skid backpressure, illegal encodings, reset.
module tb_cpu_decode;
  import CPU_Defines::*;

  logic i_clock = 1'b0;
  logic i_reset;
  always #5 i_clock = ~i_clock;

  cpu_decode_if bus ();
  cpu_decode dut (.i_clock(i_clock), .i_reset(i_reset), .bus(bus));

  int   total = 0;
  int   bad   = 0;
  logic stb   = 1'b0;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    stb = ~stb;
    bus.i_data.strobe      = stb;
    bus.i_data.instruction = instr;
    bus.i_data.pc          = pc;
    bus.i_data.inst_rs1    = rs1;
    bus.i_data.inst_rs2    = rs2;
    bus.i_data.inst_rd     = rd;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; bus.i_busy = 1'b0; bus.i_data = '0; stb = 1'b0;
    repeat (3) tick();
    total++; if (bus.o_data !== '0) begin bad++; $display("FAIL reset_odata got=%h want=0", bus.o_data); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_obusy got=%b want=0", bus.o_busy); end
    bus.i_busy = 1'b1; #1;
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL reset_obusy_follow got=%b want=1", bus.o_busy); end
    bus.i_busy = 1'b0; i_reset = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    drive(32'hFFF30293, 32'h100, 5'd6, 5'd0, 5'd5);
    tick();
    total++; if (bus.o_data.strobe !== 1'b1) begin bad++; $display("FAIL addi_strobe got=%b want=1", bus.o_data.strobe); end
    total++; if (bus.o_data.imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h want=ffffffff", bus.o_data.imm); end
    total++; if (bus.o_data.alu_op !== ALU_ADD || bus.o_data.is_op_imm !== 1'b1) begin bad++; $display("FAIL addi_class got alu=%0d opimm=%b want alu=0 opimm=1", bus.o_data.alu_op, bus.o_data.is_op_imm); end
    total++; if (bus.o_data.rd !== 5'd5 || bus.o_data.rs1 !== 5'd6 || bus.o_data.pc !== 32'h100) begin bad++; $display("FAIL addi_regs got rd=%0d rs1=%0d pc=%h want 5 6 100", bus.o_data.rd, bus.o_data.rs1, bus.o_data.pc); end
    total++; if (bus.o_data.illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%b want=0", bus.o_data.illegal); end
  endtask

  task automatic test_load_branch();
    drive(32'h00812083, 32'h104, 5'd2, 5'd0, 5'd1);
    tick();
    total++; if (bus.o_data.is_load !== 1'b1 || bus.o_data.mem_width !== 2'd2 || bus.o_data.mem_signed !== 1'b1) begin bad++; $display("FAIL lw_attr got ld=%b w=%0d s=%b want 1 2 1", bus.o_data.is_load, bus.o_data.mem_width, bus.o_data.mem_signed); end
    total++; if (bus.o_data.imm !== 32'd8 || bus.o_data.strobe !== stb) begin bad++; $display("FAIL lw_imm got imm=%h stb=%b want 8 %b", bus.o_data.imm, bus.o_data.strobe, stb); end
    drive(32'hFE000EE3, 32'h108, 5'd0, 5'd0, 5'd0);
    tick();
    total++; if (bus.o_data.is_branch !== 1'b1 || bus.o_data.branch_cond !== BR_EQ) begin bad++; $display("FAIL beq_class got br=%b cond=%0d want 1 0", bus.o_data.is_branch, bus.o_data.branch_cond); end
    total++; if (bus.o_data.imm !== 32'hFFFFFFFC) begin bad++; $display("FAIL beq_imm got=%h want=fffffffc", bus.o_data.imm); end
  endtask

  task automatic test_hold();
    repeat (2) tick();
    total++; if (bus.o_data.strobe !== stb || bus.o_data.pc !== 32'h108) begin bad++; $display("FAIL hold got stb=%b pc=%h want %b 108", bus.o_data.strobe, bus.o_data.pc, stb); end
  endtask

  task automatic test_skid();
    logic prev;
    prev = stb;
    bus.i_busy = 1'b1;
    drive(32'h123453B7, 32'h200, 5'd0, 5'd0, 5'd7);
    #1;
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL skid_busy_now got=%b want=1", bus.o_busy); end
    tick();
    total++; if (bus.o_data.strobe !== prev) begin bad++; $display("FAIL skid_no_toggle got=%b want=%b", bus.o_data.strobe, prev); end
    repeat (2) tick();
    bus.i_busy = 1'b0; #1;
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL skid_full_busy got=%b want=1", bus.o_busy); end
    total++; if (bus.o_data.strobe !== prev) begin bad++; $display("FAIL skid_still_held got=%b want=%b", bus.o_data.strobe, prev); end
    tick();
    total++; if (bus.o_data.strobe !== stb || bus.o_data.pc !== 32'h200) begin bad++; $display("FAIL skid_emit got stb=%b pc=%h want %b 200", bus.o_data.strobe, bus.o_data.pc, stb); end
    total++; if (bus.o_data.is_lui !== 1'b1 || bus.o_data.alu_op !== ALU_PASS_B || bus.o_data.imm !== 32'h12345000 || bus.o_data.rd !== 5'd7) begin bad++; $display("FAIL skid_lui got lui=%b alu=%0d imm=%h rd=%0d want 1 10 12345000 7", bus.o_data.is_lui, bus.o_data.alu_op, bus.o_data.imm, bus.o_data.rd); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL skid_drained got=%b want=0", bus.o_busy); end
  endtask

  task automatic test_muldiv();
    drive(32'h022081B3, 32'h300, 5'd1, 5'd2, 5'd3);
    tick();
`ifdef CPU_DECODE_RV32M_EN
    total++; if (bus.o_data.is_muldiv !== 1'b1 || bus.o_data.muldiv_op !== 3'd0 || bus.o_data.illegal !== 1'b0) begin bad++; $display("FAIL mul_decode got md=%b op=%0d ill=%b want 1 0 0", bus.o_data.is_muldiv, bus.o_data.muldiv_op, bus.o_data.illegal); end
`else
    total++; if (bus.o_data.is_muldiv !== 1'b0 || bus.o_data.illegal !== 1'b1) begin bad++; $display("FAIL mul_illegal got md=%b ill=%b want 0 1", bus.o_data.is_muldiv, bus.o_data.illegal); end
`endif
    total++; if (bus.o_data.strobe !== stb) begin bad++; $display("FAIL mul_strobe got=%b want=%b", bus.o_data.strobe, stb); end
  endtask

  task automatic test_illegal();
    drive(32'h00000000, 32'h400, 5'd0, 5'd0, 5'd0);
    tick();
    total++; if (bus.o_data.illegal !== 1'b1 || bus.o_data.strobe !== stb) begin bad++; $display("FAIL ill_zero got ill=%b stb=%b want 1 %b", bus.o_data.illegal, bus.o_data.strobe, stb); end
    drive(32'hFFFFFFFF, 32'h404, 5'd31, 5'd31, 5'd31);
    tick();
    total++; if (bus.o_data.illegal !== 1'b1 || bus.o_data.strobe !== stb) begin bad++; $display("FAIL ill_ones got ill=%b stb=%b want 1 %b", bus.o_data.illegal, bus.o_data.strobe, stb); end
  endtask

  task automatic test_back_to_back();
    drive(32'h002081B3, 32'h500, 5'd1, 5'd2, 5'd3);
    tick();
    total++; if (bus.o_data.alu_op !== ALU_ADD || bus.o_data.is_op !== 1'b1 || bus.o_data.imm !== 32'd0 || bus.o_data.illegal !== 1'b0) begin bad++; $display("FAIL b2b_add got alu=%0d op=%b imm=%h ill=%b want 0 1 0 0", bus.o_data.alu_op, bus.o_data.is_op, bus.o_data.imm, bus.o_data.illegal); end
    drive(32'h402081B3, 32'h504, 5'd1, 5'd2, 5'd3);
    tick();
    total++; if (bus.o_data.alu_op !== ALU_SUB || bus.o_data.illegal !== 1'b0 || bus.o_data.pc !== 32'h504) begin bad++; $display("FAIL b2b_sub got alu=%0d ill=%b pc=%h want 1 0 504", bus.o_data.alu_op, bus.o_data.illegal, bus.o_data.pc); end
    drive(32'h402091B3, 32'h508, 5'd1, 5'd2, 5'd3);
    tick();
    total++; if (bus.o_data.illegal !== 1'b1 || bus.o_data.strobe !== stb) begin bad++; $display("FAIL b2b_badf7 got ill=%b stb=%b want 1 %b", bus.o_data.illegal, bus.o_data.strobe, stb); end
  endtask

  task automatic test_reset_mid();
    bus.i_busy = 1'b1;
    drive(32'h00100073, 32'h600, 5'd0, 5'd0, 5'd0);
    tick();
    i_reset = 1'b1; bus.i_busy = 1'b0; stb = 1'b0; bus.i_data.strobe = 1'b0;
    tick();
    total++; if (bus.o_data !== '0) begin bad++; $display("FAIL rstmid_odata got=%h want=0", bus.o_data); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_obusy got=%b want=0", bus.o_busy); end
    i_reset = 1'b0;
    tick();
    total++; if (bus.o_data.strobe !== 1'b0) begin bad++; $display("FAIL rstmid_no_emit got=%b want=0", bus.o_data.strobe); end
    drive(32'hFFF30293, 32'h700, 5'd6, 5'd0, 5'd5);
    tick();
    total++; if (bus.o_data.strobe !== 1'b1 || bus.o_data.imm !== 32'hFFFFFFFF || bus.o_data.pc !== 32'h700) begin bad++; $display("FAIL rstmid_fresh got stb=%b imm=%h pc=%h want 1 ffffffff 700", bus.o_data.strobe, bus.o_data.imm, bus.o_data.pc); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_branch();
    test_hold();
    test_skid();
    test_muldiv();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
